// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: pipeline sequencing controller for the 5-stage RV32 core.
// Tracks in-flight register writers in a shadow pipeline (EX, MEM, WB) and derives
// PC / pipeline-register enables, bubbles and flushes combinationally each cycle.
//
// Optional feature macro: PIPE_FWD_EN
//   undefined : any RAW match against EX or MEM stalls; fwd_a_o/fwd_b_o tied to 00.
//   defined   : only load-use stalls; registered operand forwarding selects are produced.
//
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   id_rs1_i, id_rs2_i      source registers of the ID instruction (0 = unused)
//   id_rd_i                 destination register of the ID instruction
//   id_regwrite_i           ID instruction writes rd
//   id_memread_i            ID instruction is a load
//   id_memwrite_i           ID instruction is a store
//   ex_redirect_i           branch/jump resolved taken in EX
//   mem_ready_i             data memory completes the MEM access this cycle
//   pc_we_o, ifid_we_o      PC and IF/ID load enables
//   ifid_flush_o            IF/ID cleared to NOP
//   idex_flush_o            ID/EX loaded with a bubble
//   pipe_we_o               ID/EX, EX/MEM, MEM/WB load enable
//   fwd_a_o, fwd_b_o        EX operand sources (01 EX/MEM, 10 MEM/WB, 00 regfile)
//   stall_cnt_o             saturating count of cycles with pc_we_o = 0
module pipe_hazard_ctrl #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       id_rs1_i,
    input  logic [4:0]       id_rs2_i,
    input  logic [4:0]       id_rd_i,
    input  logic             id_regwrite_i,
    input  logic             id_memread_i,
    input  logic             id_memwrite_i,
    input  logic             ex_redirect_i,
    input  logic             mem_ready_i,
    output logic             pc_we_o,
    output logic             ifid_we_o,
    output logic             ifid_flush_o,
    output logic             idex_flush_o,
    output logic             pipe_we_o,
    output logic [1:0]       fwd_a_o,
    output logic [1:0]       fwd_b_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       regwrite;
        logic       memread;
        logic       memaccess;
    } shadow_t;

    shadow_t ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic freeze, hazard, bubble;

    function automatic logic writes(input shadow_t e, input logic [4:0] rs);
        return e.valid && e.regwrite && (e.rd != 5'd0) && (e.rd == rs);
    endfunction

    // The WB stage is tracked for completeness; the write-first register file
    // means it never participates in a hazard decision.
    logic unused_wb;
    assign unused_wb = ^wb_q;

    assign freeze = mem_q.valid && mem_q.memaccess && !mem_ready_i;

`ifdef PIPE_FWD_EN
    // Only a load still in EX cannot be forwarded in time.
    assign hazard = (writes(ex_q, id_rs1_i) || writes(ex_q, id_rs2_i)) && ex_q.memread;
`else
    assign hazard = writes(ex_q, id_rs1_i) || writes(ex_q, id_rs2_i) ||
                    writes(mem_q, id_rs1_i) || writes(mem_q, id_rs2_i);
`endif

    // Redirect squashes the ID instruction, so it also becomes a bubble.
    assign bubble = ex_redirect_i || hazard;

    // Control outputs, one priority case per cycle.
    always_comb begin
        pc_we_o      = 1'b1;
        ifid_we_o    = 1'b1;
        ifid_flush_o = 1'b0;
        idex_flush_o = 1'b0;
        pipe_we_o    = 1'b1;
        if (freeze) begin
            pc_we_o   = 1'b0;
            ifid_we_o = 1'b0;
            pipe_we_o = 1'b0;
        end else if (ex_redirect_i) begin
            ifid_flush_o = 1'b1;
            idex_flush_o = 1'b1;
        end else if (hazard) begin
            pc_we_o      = 1'b0;
            ifid_we_o    = 1'b0;
            idex_flush_o = 1'b1;
        end
    end

    // Shadow pipeline advance; a freeze holds every stage.
    always_comb begin
        ex_d  = ex_q;
        mem_d = mem_q;
        wb_d  = wb_q;
        if (!freeze) begin
            wb_d  = mem_q;
            mem_d = ex_q;
            if (bubble) begin
                ex_d = '0;
            end else begin
                ex_d.valid     = 1'b1;
                ex_d.rd        = id_rd_i;
                ex_d.regwrite  = id_regwrite_i;
                ex_d.memread   = id_memread_i;
                ex_d.memaccess = id_memread_i | id_memwrite_i;
            end
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!pc_we_o && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ex_q        <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            stall_cnt_q <= '0;
        end else begin
            ex_q        <= ex_d;
            mem_q       <= mem_d;
            wb_q        <= wb_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;

`ifdef PIPE_FWD_EN
    logic [1:0] fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;

    // Evaluated against the producers before they advance: the one in EX now
    // sits in EX/MEM next cycle, the one in MEM sits in MEM/WB.
    function automatic logic [1:0] fwd_sel(input shadow_t ex_e, input shadow_t mem_e,
                                           input logic [4:0] rs);
        if (writes(ex_e, rs)) begin
            return 2'b01;
        end else if (writes(mem_e, rs)) begin
            return 2'b10;
        end
        return 2'b00;
    endfunction

    always_comb begin
        fwd_a_d = fwd_a_q;
        fwd_b_d = fwd_b_q;
        if (!freeze) begin
            fwd_a_d = bubble ? 2'b00 : fwd_sel(ex_q, mem_q, id_rs1_i);
            fwd_b_d = bubble ? 2'b00 : fwd_sel(ex_q, mem_q, id_rs2_i);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fwd_a_q <= 2'b00;
            fwd_b_q <= 2'b00;
        end else begin
            fwd_a_q <= fwd_a_d;
            fwd_b_q <= fwd_b_d;
        end
    end

    assign fwd_a_o = fwd_a_q;
    assign fwd_b_o = fwd_b_q;
`else
    assign fwd_a_o = 2'b00;
    assign fwd_b_o = 2'b00;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: a driver issues one ID-stage instruction per
// cycle and pushes the reference model's expected outputs; a monitor pops and compares
// on the falling edge. A second instance with a 4-bit counter checks saturation.
module tb_pipe_hazard_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic [4:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
    logic       id_regwrite = 0, id_memread = 0, id_memwrite = 0;
    logic       ex_redirect = 0, mem_ready = 1;

    logic        pc_we, ifid_we, ifid_flush, idex_flush, pipe_we;
    logic [1:0]  fwd_a, fwd_b;
    logic [15:0] stall_cnt;
    logic        pc_we4, ifid_we4, ifid_flush4, idex_flush4, pipe_we4;
    logic [1:0]  fwd_a4, fwd_b4;
    logic [3:0]  stall_cnt4;

    pipe_hazard_ctrl #(.CNT_W(16)) u_dut (
        .clk_i(clk), .rst_i(rst),
        .id_rs1_i(id_rs1), .id_rs2_i(id_rs2), .id_rd_i(id_rd),
        .id_regwrite_i(id_regwrite), .id_memread_i(id_memread), .id_memwrite_i(id_memwrite),
        .ex_redirect_i(ex_redirect), .mem_ready_i(mem_ready),
        .pc_we_o(pc_we), .ifid_we_o(ifid_we), .ifid_flush_o(ifid_flush),
        .idex_flush_o(idex_flush), .pipe_we_o(pipe_we),
        .fwd_a_o(fwd_a), .fwd_b_o(fwd_b), .stall_cnt_o(stall_cnt)
    );

    pipe_hazard_ctrl #(.CNT_W(4)) u_dut4 (
        .clk_i(clk), .rst_i(rst),
        .id_rs1_i(id_rs1), .id_rs2_i(id_rs2), .id_rd_i(id_rd),
        .id_regwrite_i(id_regwrite), .id_memread_i(id_memread), .id_memwrite_i(id_memwrite),
        .ex_redirect_i(ex_redirect), .mem_ready_i(mem_ready),
        .pc_we_o(pc_we4), .ifid_we_o(ifid_we4), .ifid_flush_o(ifid_flush4),
        .idex_flush_o(idex_flush4), .pipe_we_o(pipe_we4),
        .fwd_a_o(fwd_a4), .fwd_b_o(fwd_b4), .stall_cnt_o(stall_cnt4)
    );

    // Reference model: the instructions currently occupying EX and MEM.
    typedef struct {
        bit v;
        int rd;
        bit wr;
        bit ld;
        bit acc;
    } instr_t;

    // ctrl = {pc_we, ifid_we, ifid_flush, idex_flush, pipe_we}
    typedef struct {
        bit [4:0] ctrl;
        bit [1:0] fa;
        bit [1:0] fb;
        int       c16;
        int       c4;
    } exp_t;

    exp_t   sbq[$];
    instr_t in_ex, in_mem;
    int     c16 = 0, c4 = 0;
    bit [1:0] mfa = 0, mfb = 0;
    bit     last_ifid_we = 1;
    int     total = 0, bad = 0;

    function automatic bit produces(instr_t p, int r);
        return p.v && p.wr && p.rd != 0 && p.rd == r;
    endfunction

    function automatic bit [1:0] src_of(instr_t ex_i, instr_t mem_i, int r);
        if (produces(ex_i, r)) return 2'b01;
        if (produces(mem_i, r)) return 2'b10;
        return 2'b00;
    endfunction

    task automatic cyc(input int rs1, input int rs2, input int rd, input bit wr, input bit ld,
                       input bit st, input bit redir, input bit ready, input bit rstv);
        exp_t   e;
        bit     frz, need;
        instr_t nop;
        nop = '{v: 0, rd: 0, wr: 0, ld: 0, acc: 0};
        @(posedge clk);
        #1;
        id_rs1 = 5'(rs1); id_rs2 = 5'(rs2); id_rd = 5'(rd);
        id_regwrite = wr; id_memread = ld; id_memwrite = st;
        ex_redirect = redir; mem_ready = ready; rst = rstv;
        if (rstv) begin
            in_ex = nop; in_mem = nop; c16 = 0; c4 = 0; mfa = 0; mfb = 0;
        end
        frz = in_mem.v && in_mem.acc && !ready;
`ifdef PIPE_FWD_EN
        need = (produces(in_ex, rs1) || produces(in_ex, rs2)) && in_ex.ld;
`else
        need = produces(in_ex, rs1) || produces(in_ex, rs2) ||
               produces(in_mem, rs1) || produces(in_mem, rs2);
`endif
        if (frz)        e.ctrl = 5'b00000;
        else if (redir) e.ctrl = 5'b11111;
        else if (need)  e.ctrl = 5'b00011;
        else            e.ctrl = 5'b11001;
        e.fa = mfa; e.fb = mfb; e.c16 = c16; e.c4 = c4;
        sbq.push_back(e);
        last_ifid_we = e.ctrl[3];
        if (!rstv) begin
            if (!e.ctrl[4]) begin
                c16 = (c16 < 65535) ? c16 + 1 : 65535;
                c4  = (c4 < 15) ? c4 + 1 : 15;
            end
            if (!frz) begin
`ifdef PIPE_FWD_EN
                mfa = (redir || need) ? 2'b00 : src_of(in_ex, in_mem, rs1);
                mfb = (redir || need) ? 2'b00 : src_of(in_ex, in_mem, rs2);
`endif
                in_mem = in_ex;
                if (redir || need) in_ex = nop;
                else in_ex = '{v: 1, rd: rd, wr: wr, ld: ld, acc: ld | st};
            end
        end
    endtask

    // Present an instruction in ID and keep it there while the controller stalls it.
    task automatic issue(input int rs1, input int rs2, input int rd, input bit wr,
                         input bit ld, input bit st);
        int n;
        cyc(rs1, rs2, rd, wr, ld, st, 0, 1, 0);
        n = 0;
        while (!last_ifid_we && n < 20) begin
            cyc(rs1, rs2, rd, wr, ld, st, 0, 1, 0);
            n++;
        end
        if (n >= 20) begin
            total++; bad++;
            $display("FAIL issue_budget got=stalled want=released");
        end
    endtask

    // Monitor: outputs are valid every cycle; compare away from the rising edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                total++;
                if ({pc_we, ifid_we, ifid_flush, idex_flush, pipe_we} != e.ctrl) begin
                    bad++;
                    $display("FAIL ctrl t=%0t got=%b want=%b", $time,
                             {pc_we, ifid_we, ifid_flush, idex_flush, pipe_we}, e.ctrl);
                end
                total++;
                if ({fwd_a, fwd_b} != {e.fa, e.fb}) begin
                    bad++;
                    $display("FAIL fwd t=%0t got=%b/%b want=%b/%b", $time,
                             fwd_a, fwd_b, e.fa, e.fb);
                end
                total++;
                if (int'(stall_cnt) != e.c16) begin
                    bad++;
                    $display("FAIL stall_cnt16 t=%0t got=%0d want=%0d", $time, stall_cnt, e.c16);
                end
                total++;
                if (int'(stall_cnt4) != e.c4 || pc_we4 != e.ctrl[4]) begin
                    bad++;
                    $display("FAIL stall_cnt4 t=%0t got=%0d/%b want=%0d/%b", $time,
                             stall_cnt4, pc_we4, e.c4, e.ctrl[4]);
                end
            end
        end
    end

    initial begin
        int rs1, rs2, rd;
        bit wr, ld, st;
        in_ex  = '{v: 0, rd: 0, wr: 0, ld: 0, acc: 0};
        in_mem = in_ex;

        // Reset, then idle NOPs.
        repeat (2) cyc(0, 0, 0, 0, 0, 0, 0, 1, 1);
        repeat (3) cyc(0, 0, 0, 0, 0, 0, 0, 1, 0);

        // addi x5 ; add x6,x5,x1
        issue(0, 0, 5, 1, 0, 0);
        issue(5, 1, 6, 1, 0, 0);
        repeat (3) issue(0, 0, 0, 0, 0, 0);

        // lw x7 ; add x8,x7,x7
        issue(1, 0, 7, 1, 1, 0);
        issue(7, 7, 8, 1, 0, 0);
        repeat (3) issue(0, 0, 0, 0, 0, 0);

        // Redirect coinciding with a RAW hazard in ID.
        issue(0, 0, 9, 1, 0, 0);
        cyc(9, 9, 10, 1, 0, 0, 1, 1, 0);
        repeat (3) issue(0, 0, 0, 0, 0, 0);

        // Store reaches MEM and waits three cycles for memory.
        issue(1, 2, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 0);
        repeat (3) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) cyc(0, 0, 0, 0, 0, 0, 0, 1, 0);

        // Back-to-back dependent pairs to push the 4-bit counter into saturation.
        for (int i = 0; i < 20; i++) begin
            issue(0, 0, 3, 1, 1, 0);
            issue(3, 0, 4, 1, 0, 0);
        end

        // Reset asserted while a load is frozen in MEM.
        issue(0, 0, 3, 1, 1, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 0);

        // Random traffic over a small register set to provoke dependencies.
        rs1 = 0; rs2 = 0; rd = 0; wr = 0; ld = 0; st = 0;
        for (int i = 0; i < 1500; i++) begin
            if (last_ifid_we) begin
                rs1 = int'($urandom_range(0, 3));
                rs2 = int'($urandom_range(0, 3));
                rd  = int'($urandom_range(0, 3));
                ld  = ($urandom_range(0, 3) == 0);
                st  = !ld && ($urandom_range(0, 4) == 0);
                wr  = !st && ($urandom_range(0, 3) != 0);
            end
            cyc(rs1, rs2, rd, wr, ld, st, $urandom_range(0, 11) == 0,
                $urandom_range(0, 3) != 0, 0);
        end

        for (int i = 0; i < 5 && sbq.size() > 0; i++) @(posedge clk);
        @(posedge clk);
        if (sbq.size() > 0) begin
            total++; bad++;
            $display("FAIL drain got=%0d want=0", sbq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage RV32 core (IF, ID, EX, MEM, WB).
- Consumes per-instruction control fields from the decoder plus EX redirect and data-memory ready.
- Keeps a shadow pipeline of in-flight register writers.
- Drives PC and pipeline-register write enables, bubbles and flushes. Optionally drives ALU operand forwarding selects.

Parameters:
- CNT_W, 16, width of the saturating stall-cycle performance counter.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- id_rs1  in  5  rs1 address of the instruction in ID; 0 = unused.
- id_rs2  in  5  rs2 address of the instruction in ID; 0 = unused.
- id_rd  in  5  destination register of the instruction in ID.
- id_regwrite  in  1  ID instruction writes rd.
- id_memread  in  1  ID instruction is a load.
- id_memwrite  in  1  ID instruction is a store.
- ex_redirect  in  1  branch taken or jump resolved by the instruction in EX.
- mem_ready  in  1  data memory completes the access in MEM this cycle.
- pc_we  out  1  PC register load enable.
- ifid_we  out  1  IF/ID register write enable.
- ifid_flush  out  1  IF/ID register cleared to NOP on the next edge.
- idex_flush  out  1  ID/EX register loaded with a bubble instead of the ID instruction.
- pipe_we  out  1  ID/EX, EX/MEM and MEM/WB register write enable.
- fwd_a  out  2  EX operand-A source (FWD_EN only; otherwise tied to 0).
- fwd_b  out  2  EX operand-B source (FWD_EN only; otherwise tied to 0).
- stall_cnt  out  CNT_W  count of cycles in which pc_we = 0.

Behaviour:
- Shadow stages ex_q, mem_q, wb_q. Each holds {valid, rd, regwrite, memread, memaccess}.
- All shadow fields reset to 0. stall_cnt resets to 0. fwd_a and fwd_b reset to 00.
- Control outputs are combinational from shadow state and current inputs. Zero-cycle response.
- Register file is write-first, so wb_q never causes a hazard.
- Writer match: entry valid && regwrite && rd != 0 && rd == (id_rs1 or id_rs2).
- Evaluation priority, one case per cycle:
  - 1. freeze = mem_q.valid && mem_q.memaccess && !mem_ready. All enables 0, no flush, shadow holds, fwd holds. ex_redirect is held by the frozen EX stage and is acted on once the freeze clears.
  - 2. redirect = ex_redirect. pc_we=1, ifid_flush=1, idex_flush=1, pipe_we=1, ifid_we=1. Redirect wins over a simultaneous data hazard.
  - 3. hazard, defined per build in Optional Feature. pc_we=0, ifid_we=0, idex_flush=1, pipe_we=1.
  - 4. normal: pc_we=ifid_we=pipe_we=1, flushes 0.
- Shadow advance when not frozen: wb_q<=mem_q, mem_q<=ex_q. ex_q<=bubble (valid=0) on redirect or hazard, else the ID fields with valid=1 and memaccess=id_memread|id_memwrite.
- stall_cnt increments every cycle with pc_we=0 (freeze or hazard) and saturates at all-ones.
- Reset mid-stall or mid-freeze: all shadow entries invalid. The first cycle after reset release is a normal cycle.

Optional Feature:
- Macro: PIPE_FWD_EN.
- Without it:
  - Hazard = writer match in ex_q or mem_q.
  - fwd_a and fwd_b are constant 00.
- With it:
  - Hazard = load-use only: writer match in ex_q with ex_q.memread.
  - fwd_a and fwd_b are registered and updated with the ex_q advance. They are aligned with the instruction then in EX.
  - Codes: 01 = EX/MEM result (producer was in ex_q); 10 = MEM/WB result (producer was in mem_q); 00 = register file.
  - ex_q match has priority over mem_q match.
  - A bubble loads 00.

Test Plan:
- Reset with mem_ready=1 and no instructions -> pc_we=ifid_we=pipe_we=1, flushes 0, stall_cnt=0.
- addi x5 then add x6,x5,x1 back-to-back, no FWD -> 2 cycles of pc_we=0 with idex_flush=1, stall_cnt=2. With FWD -> no stall, fwd_a=01 for the add in EX.
- lw x7 then add x8,x7,x7 with FWD -> exactly 1 stall cycle, then fwd_a=fwd_b=10.
- ex_redirect=1 in the same cycle as a RAW hazard in ID -> pc_we=1, ifid_flush=1, idex_flush=1, stall_cnt unchanged.
- Store in MEM with mem_ready=0 for 3 cycles -> all enables 0 for 3 cycles, shadow frozen, stall_cnt+=3, normal flow resumes when mem_ready=1.
- CNT_W=4, force 20 hazard cycles -> stall_cnt saturates at 15. Assert rst mid-freeze -> stall_cnt=0 and pc_we=1 immediately.
